// File: rtl/demux_1_n_stream.sv
// demux_1_n_stream: routes valid/ready packets to one of CH output channels.
// Packets with an out-of-range select are discarded and counted.
module demux_1_n_stream #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_last,
  output logic [CH-1:0]    out_valid,
  input  logic [CH-1:0]    out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [7:0]       drop_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             held_q, held_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [7:0]       drop_q, drop_d;

  logic sel_bad;
  logic xfer;
  logic accept;
  logic load;
  logic drop;

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < CH; k++) begin
      out_valid[k] = held_q && (int'(ch_q) == k);
    end
  end

  assign out_data = data_q;
  assign out_last = last_q;
  assign drop_cnt = drop_q;

  assign sel_bad = int'(in_sel) >= CH;
  // out_valid is one-hot on ch_q, so this is out_ready[ch_q] gated by held
  assign xfer    = |(out_valid & out_ready);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = sel_bad || !held_q || xfer;
      FWD:     in_ready = !held_q || xfer;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready && rst_n;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_bad) begin
            drop    = 1'b1;
            state_d = in_last ? IDLE : DROP;
          end else begin
            load    = 1'b1;
            ch_d    = in_sel;
            state_d = in_last ? IDLE : FWD;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load = 1'b1;
          if (in_last) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept) begin
          drop = 1'b1;
          if (in_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    last_d = last_q;
    drop_d = drop_q;
    if (load) begin
      held_d = 1'b1;
      data_d = in_data;
      last_d = in_last;
    end else if (xfer) begin
      held_d = 1'b0;
    end
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      held_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      held_q  <= held_d;
      data_q  <= data_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// tb_demux_1_n_stream: directed vectors for the 1-to-N stream demux.
// An 8-channel and a 6-channel instance share the input stimulus.
module tb_demux_1_n_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_last;
  logic [7:0] out_ready;

  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] drop_cnt;

  logic       in_ready6;
  logic [5:0] out_valid6;
  logic [7:0] out_data6;
  logic       out_last6;
  logic [7:0] drop_cnt6;

  int checks;
  int errors;

  demux_1_n_stream #(.WIDTH(8), .CH(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .drop_cnt(drop_cnt)
  );

  demux_1_n_stream #(.WIDTH(8), .CH(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready6),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid6), .out_ready(out_ready[5:0]),
    .out_data(out_data6), .out_last(out_last6),
    .drop_cnt(drop_cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
    logic [7:0] ev;
    logic       el;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    int idx;
    int bad;
    logic [7:0] rx[$];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    out_ready = 8'hFF;
    drive(1'b1, 3'd2, 8'h5A, 1'b1);

    for (int i = 0; i < 8; i++) begin
      tv[i] = '{sel: 3'(i), data: 8'hA0 + 8'(i), last: 1'b1,
                ev: 8'h01 << i, el: 1'b1};
    end
    tv[8]  = '{sel: 3'd5, data: 8'd11, last: 1'b0, ev: 8'h20, el: 1'b0};
    tv[9]  = '{sel: 3'd2, data: 8'd22, last: 1'b0, ev: 8'h20, el: 1'b0};
    tv[10] = '{sel: 3'd2, data: 8'd33, last: 1'b0, ev: 8'h20, el: 1'b0};
    tv[11] = '{sel: 3'd2, data: 8'd44, last: 1'b1, ev: 8'h20, el: 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tv[i].sel, tv[i].data, tv[i].last);
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tv[i].data));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tv[i].el));
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);

    idx = 0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c >= 2 && c <= 4) ? 8'hF7 : 8'hFF;
      if (idx < 6) drive(1'b1, 3'd3, 8'h30 + 8'(idx), idx == 5);
      else drive(1'b0, 3'd0, 8'h00, 1'b0);
      #1;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_stall%0d_ready", c), 32'(in_ready), 32'd0);
        chk($sformatf("bp_stall%0d_data", c), 32'(out_data), 32'h31);
      end
      if (c >= 5 && c <= 8)
        chk($sformatf("bp_resume%0d_ready", c), 32'(in_ready), 32'd1);
      if (out_valid[3] && out_ready[3]) rx.push_back(out_data);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    chk("bp_rx_count", 32'(rx.size()), 32'd6);
    for (int i = 0; i < rx.size() && i < 6; i++)
      chk($sformatf("bp_rx%0d", i), 32'(rx[i]), 32'h30 + 32'(i));

    out_ready = 8'hFE;
    drive(1'b1, 3'd0, 8'hC0, 1'b1);
    #1 chk("sw_first_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 3'd7, 8'hC7, 1'b1);
    #1 chk("sw_block_ready", 32'(in_ready), 32'd0);
    chk("sw_hold_valid", 32'(out_valid), 32'h01);
    @(negedge clk);
    chk("sw_still_valid", 32'(out_valid), 32'h01);
    chk("sw_still_data", 32'(out_data), 32'hC0);
    out_ready = 8'hFF;
    #1 chk("sw_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("sw_ch7_valid", 32'(out_valid), 32'h80);
    chk("sw_ch7_data", 32'(out_data), 32'hC7);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("sw_idle_valid", 32'(out_valid), 32'd0);

    drive(1'b1, 3'd1, 8'h71, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd1, 8'h72, 1'b0);
    @(negedge clk);
    chk("mid_pre_valid", 32'(out_valid), 32'h02);
    rst_n = 1'b0;
    drive(1'b0, 3'd1, 8'h73, 1'b0);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_release_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 3'd4, 8'h44, 1'b1);
    @(negedge clk);
    chk("mid_ch4_valid", 32'(out_valid), 32'h10);
    chk("mid_ch4_data", 32'(out_data), 32'h44);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 1 || i == 2) ? 3'd0 : 3'd7, 8'hD0 + 8'(i),
            i >= 2);
      #1;
      chk($sformatf("drop%0d_ready", i), 32'(in_ready6), 32'd1);
      chk($sformatf("drop%0d_valid", i), 32'(out_valid6), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    #1;
    chk("drop_cnt4", 32'(drop_cnt6), 32'd4);
    chk("drop_valid_after", 32'(out_valid6), 32'd0);

    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 3'd7, 8'(i), 1'b1);
      #1;
      if (!in_ready6 || out_valid6 != 6'd0) bad++;
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    chk("sat_ready_valid", 32'(bad), 32'd0);
    chk("sat_drop_cnt", 32'(drop_cnt6), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1_n_stream.md
DEMUX_1_N_STREAM -- requirements
Module: demux_1_n_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width in bits.
REQ-002 The block SHALL have parameter CH, default 8, the number of output channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 3, the select width; CH SHALL be no greater than 2^SEL_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts the input beat this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: beat payload.
REQ-009 The block SHALL have port in_sel, input, SEL_W bits: destination channel, sampled on the first beat of a packet.
REQ-010 The block SHALL have port in_last, input, 1 bit: final beat of the packet.
REQ-011 The block SHALL have port out_valid, output, CH bits: one-hot or zero; bit k means channel k holds a beat.
REQ-012 The block SHALL have port out_ready, input, CH bits: per-channel consumer ready.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: shared payload, meaningful only while out_valid is nonzero.
REQ-014 The block SHALL have port out_last, output, 1 bit: last flag of the held beat.
REQ-015 The block SHALL have port drop_cnt, output, 8 bits: saturating count of discarded beats.

Function
REQ-016 An input beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; an output beat SHALL transfer only in a cycle where out_valid[k] and out_ready[k] are both 1.
REQ-017 The FSM SHALL have exactly three states: IDLE (awaiting first beat), FWD (packet locked to channel ch_q), DROP (packet being discarded).
REQ-018 In IDLE, an accepted beat with in_sel < CH SHALL latch ch_q = in_sel.
- If in_last = 0, the FSM SHALL go to FWD.
- If in_last = 1, the FSM SHALL stay in IDLE.
REQ-019 In IDLE, an accepted beat with in_sel >= CH SHALL be discarded and SHALL increment drop_cnt.
- If in_last = 0, the FSM SHALL go to DROP.
- If in_last = 1, the FSM SHALL stay in IDLE.
REQ-020 In FWD and DROP, in_sel SHALL be ignored; an accepted beat with in_last = 1 SHALL return the FSM to IDLE.
REQ-021 In DROP, in_ready SHALL be 1 and every accepted beat SHALL be discarded with a drop_cnt increment.
REQ-022 In IDLE with in_sel >= CH, in_ready SHALL be 1 regardless of the output register.
REQ-023 In IDLE with a valid in_sel, and in FWD, in_ready SHALL be (out_valid == 0) OR out_ready[ch_q].
- This SHALL give full throughput of 1 beat per cycle.
- This condition SHALL be combinational on out_ready only.
REQ-024 A forwarded beat SHALL appear on out_data, out_last and out_valid[ch] on the first clock edge after acceptance (1-cycle latency).
REQ-025 The held beat SHALL stay stable until transferred; ch is the latched channel, or in_sel itself on a first beat.
REQ-026 If the held beat transfers and a new beat is accepted in the same cycle, the register SHALL load the new beat with no bubble.
REQ-027 If the held beat transfers with no new beat accepted, out_valid SHALL clear to 0.
REQ-028 A new packet for a different channel SHALL be accepted only once the previous channel's held beat has transferred; at most one out_valid bit SHALL be 1 at any time.
REQ-029 drop_cnt SHALL saturate at 255 and SHALL not wrap.
REQ-030 Bits of out_ready for idle channels SHALL have no effect.

Reset
REQ-031 While rst_n = 0, the block SHALL immediately force:
- state = IDLE
- out_valid = 0
- out_data = 0
- out_last = 0
- ch_q = 0
- drop_cnt = 0
REQ-032 An assertion of rst_n mid-packet SHALL abandon the packet, with no beat emitted after release.
REQ-033 After rst_n deasserts, the first accepted beat SHALL be treated as a packet start.
REQ-034 in_ready SHALL be 0 while rst_n = 0.

Verification
REQ-035 Single-beat routing: for each sel 0..7, send data = 8'hA0 + sel with last = 1 and out_ready all 1.
- Required: out_valid = 1 << sel one cycle later.
- Required: out_data matches the sent value.
- Required: no other out_valid bit is set.
REQ-036 Packet lock: send a 4-beat packet 11, 22, 33, 44 with sel = 5 on beat 1, then sel = 2 on beats 2-4.
- Required: all four beats appear on channel 5 in order.
- Required: out_last = 1 only with 44.
REQ-037 Backpressure: hold out_ready[3] = 0 for 3 cycles during a stream to channel 3.
- Required: in_ready = 0 during the stall.
- Required: out_data is stable during the stall.
- Required: no beat is lost or duplicated.
- Required: 1 beat per cycle resumes after the stall.
REQ-038 Invalid select: with CH = 6, send a 3-beat packet with sel = 7, then a 1-beat packet with sel = 7.
- Required: no out_valid bit is set.
- Required: in_ready = 1 throughout.
- Required: drop_cnt = 4.
- Required: drop_cnt stays at 255 after 300 dropped beats.
REQ-039 Reset mid-packet: assert rst_n = 0 after beat 2 of a 4-beat packet to channel 1.
- Required: out_valid = 0 immediately.
- Required: after release, the next beat with sel = 4 routes to channel 4.
REQ-040 Channel switch: send a last beat to channel 0 while out_ready[0] = 0, then a first beat to channel 7.
- Required: the channel-7 beat is not accepted until the channel-0 beat transfers.
